// File: rtl/fb_scanout_if.sv
// Memory read port and pixel stream between fb_scanout and its neighbours.
// master: scanout side (drives o_* requests/pixels); slave: memory + sink.
interface fb_scanout_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CORD_WIDTH = 10
);
    logic                  o_mem_req;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  i_mem_gnt;
    logic                  i_mem_rvalid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  o_pix_valid;
    logic                  i_pix_ready;
    logic [DATA_WIDTH-1:0] o_pix_data;
    logic [CORD_WIDTH-1:0] o_pix_x;
    logic [CORD_WIDTH-1:0] o_pix_y;
    logic                  o_pix_sof;
    logic                  o_pix_eol;

    modport master (
        output o_mem_req, o_mem_addr,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_pix_valid, o_pix_data, o_pix_x, o_pix_y,
        output o_pix_sof, o_pix_eol,
        input  i_pix_ready
    );

    modport slave (
        input  o_mem_req, o_mem_addr,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_pix_valid, o_pix_data, o_pix_x, o_pix_y,
        input  o_pix_sof, o_pix_eol,
        output i_pix_ready
    );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scanout: raster-order memory reads, credit-limited FIFO, pixel stream.
// Ports: clk, rst_n (sync, active low), i_enable, i_fb_base, bus (mem+pixel), o_frame_done, o_busy.
module fb_scanout #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CORD_WIDTH = 10,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_fb_base,
    fb_scanout_if.master          bus,
    output logic                  o_frame_done,
    output logic                  o_busy
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNTW  = AW + 1;
    localparam int SW    = CNTW + 1;
    localparam int TOTAL = FB_WIDTH * FB_HEIGHT;
    localparam int RW    = $clog2(TOTAL + 1);

    localparam logic [RW-1:0]         TOTAL_R = RW'(TOTAL);
    localparam logic [SW-1:0]         DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [CORD_WIDTH-1:0] X_LAST  = CORD_WIDTH'(FB_WIDTH - 1);
    localparam logic [CORD_WIDTH-1:0] Y_LAST  = CORD_WIDTH'(FB_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic                  mem_req, req_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [RW-1:0]         req_cnt, req_cnt_nxt;
    logic [CNTW-1:0]       outst, outst_nxt;
    logic [CNTW-1:0]       fifo_cnt, fifo_nxt;
    logic [AW-1:0]         wptr, rptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [CORD_WIDTH-1:0] pix_x, pix_y;
    logic                  frame_done;

    logic accept, ret, pop, pix_valid, last_pix, credit_ok;

    assign accept    = mem_req & bus.i_mem_gnt;
    // Returns with nothing in flight are stray (e.g. from before a reset).
    assign ret       = bus.i_mem_rvalid & (outst != '0);
    assign pix_valid = (fifo_cnt != '0);
    assign pop       = pix_valid & bus.i_pix_ready;
    assign last_pix  = pop && (pix_x == X_LAST) && (pix_y == Y_LAST);

    assign req_cnt_nxt = req_cnt + RW'(accept);
    assign outst_nxt   = outst + CNTW'(accept) - CNTW'(ret);
    assign fifo_nxt    = fifo_cnt + CNTW'(ret) - CNTW'(pop);
    // Every in-flight read must have a guaranteed FIFO slot.
    assign credit_ok   = ({1'b0, fifo_nxt} + {1'b0, outst_nxt}) < DEPTH_S;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_enable) begin
                    state_nxt = FETCH;
                    req_nxt   = 1'b1;
                end
            end
            FETCH: begin
                if (req_cnt_nxt == TOTAL_R) begin
                    state_nxt = DRAIN;
                end else if (mem_req && !bus.i_mem_gnt) begin
                    req_nxt = 1'b1;
                end else begin
                    req_nxt = credit_ok;
                end
            end
            DRAIN: begin
                if (last_pix) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            addr       <= '0;
            req_cnt    <= '0;
            outst      <= '0;
            fifo_cnt   <= '0;
            wptr       <= '0;
            rptr       <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            mem_req    <= req_nxt;
            frame_done <= (state != IDLE) && last_pix;
            outst      <= outst_nxt;
            fifo_cnt   <= fifo_nxt;
            if (ret) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (state == IDLE && i_enable) begin
                addr    <= i_fb_base;
                req_cnt <= '0;
                pix_x   <= '0;
                pix_y   <= '0;
            end else begin
                req_cnt <= req_cnt_nxt;
                if (accept) begin
                    addr <= addr + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    if (pix_x == X_LAST) begin
                        pix_x <= '0;
                        pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + CORD_WIDTH'(1);
                    end else begin
                        pix_x <= pix_x + CORD_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && ret) begin
            fifo_mem[wptr] <= bus.i_mem_rdata;
        end
    end

    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_addr  = addr;
    assign bus.o_pix_valid = pix_valid;
    // Gate the array read so the bus shows zero while the FIFO is empty.
    assign bus.o_pix_data  = pix_valid ? fifo_mem[rptr] : '0;
    assign bus.o_pix_x     = pix_x;
    assign bus.o_pix_y     = pix_y;
    assign bus.o_pix_sof   = pix_valid && (pix_x == '0) && (pix_y == '0);
    assign bus.o_pix_eol   = pix_valid && (pix_x == X_LAST);
    assign o_frame_done    = frame_done;
    assign o_busy          = (state != IDLE);

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a 4x2 frame with a 4-entry FIFO.
// Memory returns addr ^ MASK one cycle after each accepted request.
module tb_fb_scanout;

    localparam int          FW    = 4;
    localparam int          FH    = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] MASK  = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [31:0] i_fb_base;
    logic        o_frame_done;
    logic        o_busy;

    fb_scanout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CORD_WIDTH(10)) bus ();

    fb_scanout #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CORD_WIDTH(10),
        .FB_WIDTH(FW), .FB_HEIGHT(FH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_fb_base    (i_fb_base),
        .bus          (bus),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] acc_log [$];
    logic [53:0] pix_log [$];
    logic [31:0] rq [$];
    int          fd_n;
    int          m_out, m_ret, m_pop, ovf;
    bit          resp_en;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [53:0] exp_pix(logic [31:0] base, int i);
        logic [31:0] a;
        a = base + 32'(4 * i);
        return {a ^ MASK, 10'(i % FW), 10'(i / FW), (i == 0), ((i % FW) == FW - 1)};
    endfunction

    function automatic logic [89:0] all_outs();
        return {bus.o_mem_req, bus.o_mem_addr, bus.o_pix_valid, bus.o_pix_data,
                bus.o_pix_x, bus.o_pix_y, bus.o_pix_sof, bus.o_pix_eol,
                o_frame_done, o_busy};
    endfunction

    function automatic logic [53:0] cur_pix();
        return {bus.o_pix_data, bus.o_pix_x, bus.o_pix_y, bus.o_pix_sof, bus.o_pix_eol};
    endfunction

    // One clock: record this cycle's handshakes, advance, then drive returns.
    task automatic tick();
        logic acc, pop, rv;
        acc = bus.o_mem_req && bus.i_mem_gnt;
        pop = bus.o_pix_valid && bus.i_pix_ready;
        rv  = bus.i_mem_rvalid && (m_out != 0);
        if (!rst_n) begin
            m_out = 0;
            m_ret = 0;
            m_pop = 0;
        end else begin
            if (rv && (m_ret - m_pop) >= DEPTH) ovf++;
            if (rv) begin
                m_out--;
                m_ret++;
            end
            if (acc) begin
                acc_log.push_back(bus.o_mem_addr);
                m_out++;
                if (resp_en) rq.push_back(bus.o_mem_addr ^ MASK);
            end
            if (pop) begin
                pix_log.push_back(cur_pix());
                m_pop++;
            end
            if (o_frame_done) fd_n++;
        end
        @(posedge clk);
        #1;
        if (resp_en) begin
            if (rq.size() > 0) begin
                bus.i_mem_rvalid = 1'b1;
                bus.i_mem_rdata  = rq.pop_front();
            end else begin
                bus.i_mem_rvalid = 1'b0;
                bus.i_mem_rdata  = '0;
            end
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pix_log.delete();
        rq.delete();
        fd_n = 0;
    endtask

    task automatic start(string tag, logic [31:0] base);
        i_fb_base = base;
        i_enable  = 1'b1;
        tick();
        i_enable  = 1'b0;
        chk({tag, "_first_req"}, {o_busy, bus.o_mem_req, bus.o_mem_addr}, {1'b1, 1'b1, base});
    endtask

    task automatic run_to_done(string tag);
        int c;
        c = 0;
        while (fd_n == 0 && c < 300) begin
            tick();
            c++;
        end
        chk({tag, "_done_seen"}, 128'(fd_n != 0), 128'(1));
        repeat (3) tick();
        chk({tag, "_done_pulses"}, 128'(fd_n), 128'(1));
        chk({tag, "_idle_after"}, {o_busy, bus.o_mem_req, bus.o_pix_valid}, 128'(0));
    endtask

    task automatic check_frame(string tag, logic [31:0] base);
        chk({tag, "_n_acc"}, 128'(acc_log.size()), 128'(FW * FH));
        chk({tag, "_n_pix"}, 128'(pix_log.size()), 128'(FW * FH));
        for (int i = 0; i < FW * FH; i++) begin
            chk($sformatf("%s_addr%0d", tag, i),
                (i < acc_log.size()) ? 128'(acc_log[i]) : 128'hx,
                128'(base + 32'(4 * i)));
            chk($sformatf("%s_pix%0d", tag, i),
                (i < pix_log.size()) ? 128'(pix_log[i]) : 128'hx,
                128'(exp_pix(base, i)));
        end
    endtask

    task automatic wait_acc(string tag, int n);
        int c;
        c = 0;
        while (acc_log.size() < n && c < 50) begin
            tick();
            c++;
        end
        chk({tag, "_acc_reached"}, 128'(acc_log.size()), 128'(n));
    endtask

    initial begin
        logic [53:0] held;
        bit          stay_idle;
        rst_n            = 1'b0;
        i_enable         = 1'b0;
        i_fb_base        = '0;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        bus.i_pix_ready  = 1'b0;
        resp_en          = 1'b1;
        m_out = 0; m_ret = 0; m_pop = 0; ovf = 0;
        clear_logs();

        // Reset state
        tick();
        tick();
        chk("reset_outs", 128'(all_outs()), 128'(0));
        rst_n = 1'b1;

        // Streaming frame, sink always ready
        bus.i_mem_gnt   = 1'b1;
        bus.i_pix_ready = 1'b1;
        start("s1", 32'h1000);
        run_to_done("s1");
        check_frame("s1", 32'h1000);

        // Sink stalled: credit limits to FIFO_DEPTH reads
        clear_logs();
        bus.i_pix_ready = 1'b0;
        start("s2", 32'h1000);
        repeat (20) tick();
        chk("s2_acc_limit", 128'(acc_log.size()), 128'(DEPTH));
        chk("s2_req_low", {bus.o_mem_req, o_busy}, {1'b0, 1'b1});
        held = cur_pix();
        chk("s2_head_pix", {bus.o_pix_valid, held}, {1'b1, exp_pix(32'h1000, 0)});
        tick();
        chk("s2_head_stable", {bus.o_pix_valid, cur_pix()}, {1'b1, held});
        bus.i_pix_ready = 1'b1;
        run_to_done("s2");
        check_frame("s2", 32'h1000);

        // Grant withheld at the third request
        clear_logs();
        start("s3", 32'h1000);
        wait_acc("s3", 2);
        bus.i_mem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s3_stall%0d", i), {bus.o_mem_req, bus.o_mem_addr},
                {1'b1, 32'h1008});
            tick();
        end
        chk("s3_no_extra_acc", 128'(acc_log.size()), 128'(2));
        chk("s3_stall_end", {bus.o_mem_req, bus.o_mem_addr}, {1'b1, 32'h1008});
        bus.i_mem_gnt = 1'b1;
        run_to_done("s3");
        check_frame("s3", 32'h1000);

        // Enable dropped mid-fetch: frame completes, then stays idle
        clear_logs();
        i_fb_base = 32'h1000;
        i_enable  = 1'b1;
        wait_acc("s4", 2);
        i_enable  = 1'b0;
        run_to_done("s4");
        check_frame("s4", 32'h1000);
        stay_idle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_busy || bus.o_mem_req) stay_idle = 1'b0;
        end
        chk("s4_stays_idle", 128'(stay_idle), 128'(1));

        // Reset with two reads in flight, then stray returns
        clear_logs();
        resp_en = 1'b0;
        start("s5", 32'h1000);
        wait_acc("s5", 2);
        rst_n         = 1'b0;
        bus.i_mem_gnt = 1'b0;
        tick();
        chk("s5_reset_outs", 128'(all_outs()), 128'(0));
        rst_n            = 1'b1;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        tick();
        chk("s5_stray_ignored", {bus.o_pix_valid, o_busy, 32'(pix_log.size())}, 128'(0));

        // Clean frame at a new base after the reset
        clear_logs();
        resp_en       = 1'b1;
        bus.i_mem_gnt = 1'b1;
        start("s6", 32'h2000);
        run_to_done("s6");
        check_frame("s6", 32'h2000);

        chk("fifo_no_overflow", 128'(ovf), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
Display-side reader for the framebuffer. It fetches one frame of 32-bit pixels from main memory in raster order through one interconnect master port, buffers them in an internal FIFO, and emits a valid/ready pixel stream with x/y coordinates and frame/line markers. Outstanding reads are credit-limited so returned data never overflows the FIFO.

Parameters:
DATA_WIDTH, 32, pixel and memory data width
ADDR_WIDTH, 32, memory byte-address width
CORD_WIDTH, 10, width of pixel x/y outputs (unsigned)
FB_WIDTH, 640, pixels per line
FB_HEIGHT, 480, lines per frame
FIFO_DEPTH, 64, pixel FIFO entries; power of two, at least 2

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
i_enable  input  1  start/continue scanning frames; sampled only in IDLE
i_fb_base  input  ADDR_WIDTH  frame base byte address; latched at frame start
o_mem_req  output  1  read request
o_mem_addr  output  ADDR_WIDTH  read byte address
i_mem_gnt  input  1  request accepted this cycle when o_mem_req && i_mem_gnt
i_mem_rvalid  input  1  read data valid; returns are in order
i_mem_rdata  input  DATA_WIDTH  read data
o_pix_valid  output  1  pixel available
i_pix_ready  input  1  sink accepts the pixel when o_pix_valid && i_pix_ready
o_pix_data  output  DATA_WIDTH  pixel colour
o_pix_x  output  CORD_WIDTH  pixel column
o_pix_y  output  CORD_WIDTH  pixel row
o_pix_sof  output  1  high with pixel (0,0)
o_pix_eol  output  1  high with pixel x = FB_WIDTH-1
o_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted
o_busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - All outputs are 0; FIFO is emptied; request, outstanding, x and y counters are cleared.
- i_mem_rvalid with an outstanding count of 0 is ignored. This covers stray returns after reset.
- States:
  - IDLE: if i_enable is high, latch i_fb_base into the address register, clear counters, and go to FETCH next cycle.
  - FETCH: issue reads. After FB_WIDTH*FB_HEIGHT reads have been accepted, go to DRAIN.
  - DRAIN: no requests. Once the last pixel is accepted, pulse o_frame_done on the following cycle and go to IDLE.
  - i_enable low during FETCH or DRAIN has no effect; the frame always completes. Continuous enable gives back-to-back frames with one IDLE cycle between them.
- Request side:
  - o_mem_req is registered and is asserted in the first FETCH cycle.
  - While o_mem_req is high and i_mem_gnt is low, o_mem_req and o_mem_addr hold stable.
  - On acceptance, the address increments by 4 (ADDR_WIDTH wrap, no saturation) and the request count increments.
  - A new request is asserted only while fifo_count + outstanding < FIFO_DEPTH, evaluated with the updated counts. Otherwise o_mem_req deasserts.
  - Back-to-back acceptance (one per cycle) is supported.
- Address of pixel (x,y) is base + 4*(y*FB_WIDTH + x). It is generated by an incrementing counter; no multiplier.
- Outstanding counter:
  - increments on acceptance and decrements on rvalid;
  - a simultaneous accept and rvalid leaves it unchanged;
  - width is $clog2(FIFO_DEPTH)+1.
- FIFO:
  - Writes i_mem_rdata on rvalid. Data returned at edge M gives o_pix_valid at cycle M+1 (first-word fall-through).
  - Simultaneous write and read in the same cycle is allowed in any occupancy state.
  - A write when full is impossible by the credit rule; the bench must assert it never occurs.
- Output side:
  - o_pix_valid = FIFO not empty.
  - o_pix_data, x, y, sof and eol hold stable while valid && !ready.
  - On each accepted pixel x increments. At FB_WIDTH-1, x wraps to 0 and y increments. At the last pixel, x and y both wrap to 0.
- Reset mid-frame takes effect at the next edge regardless of state.

Test Plan:
- FB_WIDTH=4, FB_HEIGHT=2, FIFO_DEPTH=4 are used for all scenarios. Assert rst_n=0 for 2 cycles -> all outputs 0, o_busy=0.
- i_fb_base=0x1000, enable, gnt=1, rvalid 1 cycle after accept, ready=1:
  - addresses 0x1000..0x101C issued in order;
  - 8 pixels with data equal to the returned words;
  - sof on (0,0), eol on x=3 for y=0 and y=1;
  - one o_frame_done pulse.
- Same setup with ready=0:
  - exactly 4 requests accepted, then o_mem_req=0;
  - ready=1 resumes with address 0x1010;
  - 8 pixels in order.
- gnt=0 for 5 cycles at the 3rd request -> o_mem_req=1 and o_mem_addr=0x1008 stay stable throughout; no extra accepts.
- Enable dropped after the 2nd accept -> all 8 pixels still output, o_frame_done pulses, state goes to IDLE and stays there.
- rst_n=0 mid-FETCH with 2 reads outstanding:
  - all outputs are 0 next cycle;
  - subsequent rvalid pulses produce no pixels;
  - the next enable starts a clean frame at the new base.
